lane_collector: RTL and testbench
=================================

// Module: lane_collector
// PURPOSE
//  Serial-to-lane assembler sitting directly upstream of the per-lane fan-out stage.
//  Accepts one bit per handshake, packs W bits into an unpacked logic array foo[W-1:0].
//  Presents the array, one element per lane, with a valid/ready handshake.
//  A one-deep output register lets collection of the next word overlap a stalled output.
// PARAMETERS
//  W    4     lane count / word width, W >= 1
//  PAD  1'b0  fill value for lanes not written when a partial word is flushed
// PORTS
//  clk        input   1                  clock, all state on posedge
//  rst_n      input   1                  synchronous reset, active-low
//  in_valid   input   1                  in_bit is valid
//  in_ready   output  1                  block accepts in_bit this cycle
//  in_bit     input   1                  serial data, first accepted bit -> lane 0
//  flush      input   1                  pulse: emit the current partial word
//  out_valid  output  1                  foo/out_count are valid
//  out_ready  input   1                  downstream accepts the word
//  foo        output  logic [W]          unpacked array foo[W-1:0], one element per lane
//  out_count  output  $clog2(W+1)        number of real (non-pad) lanes in foo
// BEHAVIOUR
//  Interface: one clock clk; reset rst_n is synchronous and active-low.
//  Reset (rst_n=0 at posedge): out_valid=0, foo all 0, out_count=0, idx=0, state=IDLE.
//   in_ready=1 in the first cycle after reset. A partial word in flight is discarded.
//  State: stage[W-1:0] staging regs; idx 0..W-1 (width max(1,$clog2(W)));
//   FSM IDLE (idx==0), FILL (0<idx<=W-1), FLUSH_WAIT.
//  Accept = in_valid && in_ready: stage[idx]<=in_bit; idx<=idx+1.
//  load_ok = !out_valid || out_ready (output register free or draining this cycle).
//  in_ready (combinational) = (state!=FLUSH_WAIT) && ((idx!=W-1) || load_ok).
//  Word complete: accept with idx==W-1 -> foo<={stage with in_bit at lane W-1},
//   out_count<=W, out_valid<=1, idx<=0, next IDLE. Latency: out_valid one cycle after last bit.
//  Output hold: while out_valid && !out_ready, foo and out_count stay stable.
//   out_valid&&out_ready with no new load -> out_valid<=0 next cycle.
//  Back-to-back: full word completes same cycle downstream takes previous -> out_valid stays 1.
//  Flush: flush asserted in IDLE/FILL with n = idx + (accept?1:0):
//   n==0 -> ignored. n==W -> treated as normal completion.
//   0<n<W and load_ok -> foo lanes <n from stage (incl. bit accepted this cycle),
//    lanes >=n = PAD, out_count<=n, out_valid<=1, idx<=0, IDLE.
//   0<n<W and !load_ok -> bit (if any) captured, idx<=n, go FLUSH_WAIT.
//  FLUSH_WAIT: in_ready=0; flush input ignored; on first cycle with load_ok emit the
//   partial word as above and return to IDLE.
//  W==1: every accept completes a word; idx is constant 0; partial flush cannot occur.
//  out_count arithmetic unsigned; idx wraps only via explicit clear to 0, never by overflow.
// TESTING
//  T1 W=4, reset, stream 1,0,1,1 with out_ready=1 -> one cycle later out_valid=1,
//     foo[0..3]=1,0,1,1, out_count=4; in_ready=1 throughout.
//  T2 Hold out_ready=0 after word A; send 3 bits of B -> all accepted; 4th bit stalls
//     (in_ready=0) until out_ready=1, same edge loads B; foo stable = A while stalled.
//  T3 Send 1,1 then flush with out_ready=1, PAD=0 -> foo=1,1,0,0, out_count=2.
//  T4 Output full, out_ready=0, 2 bits staged, flush -> FLUSH_WAIT, in_ready=0;
//     release out_ready -> A taken, partial word (count 2) presented next cycle.
//  T5 Flush in IDLE with no accept -> no output; flush coincident with 4th bit -> count=4.
//  T6 rst_n=0 mid-word (idx=2) with out_valid=1 -> next cycle out_valid=0, foo=0,
//     next 4 bits form a clean word starting at lane 0.

Source files
------------

// File: rtl/lane_collector.sv
// Serial-to-lane assembler: packs W accepted bits into foo[W-1:0] and presents the word
// through a one-deep valid/ready output register; flush emits a PAD-filled partial word.
module lane_collector #(
   parameter int   W   = 4,
   parameter logic PAD = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_bit,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     foo [W-1:0],
   output logic [$clog2(W+1)-1:0]   out_count
);

   localparam int            IW   = (W > 1) ? $clog2(W) : 1;
   localparam int            CW   = $clog2(W + 1);
   localparam logic [IW-1:0] LAST = IW'(W - 1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      FILL       = 2'd1,
      FLUSH_WAIT = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [W-1:0]    stage_q, stage_d;
   logic            out_valid_q, out_valid_d;
   logic            foo_q [W-1:0];
   logic            foo_d [W-1:0];
   logic [CW-1:0]   count_q, count_d;

   logic            load_ok_s;
   logic            accept_s;
   logic [CW-1:0]   n_s;
   logic [W-1:0]    stage_m_s;
   logic            emit_s;
   logic [CW-1:0]   emit_n_s;

   assign load_ok_s = !out_valid_q || out_ready;
   assign in_ready  = (state_q != FLUSH_WAIT) && ((idx_q != LAST) || load_ok_s);
   assign accept_s  = in_valid && in_ready;
   assign n_s       = CW'(idx_q) + CW'(accept_s);

   assign out_valid = out_valid_q;
   assign foo       = foo_q;
   assign out_count = count_q;

   // Next-state: staging merge, FSM transitions and output-register load.
   always_comb begin
      stage_m_s = stage_q;
      if (accept_s) begin
         stage_m_s[idx_q] = in_bit;
      end else begin
         stage_m_s = stage_q;
      end

      state_d     = state_q;
      idx_d       = idx_q;
      stage_d     = stage_m_s;
      out_valid_d = out_valid_q && !out_ready;
      foo_d       = foo_q;
      count_d     = count_q;
      emit_s      = 1'b0;
      emit_n_s    = n_s;

      case (state_q)
         IDLE, FILL: begin
            if (accept_s && (idx_q == LAST)) begin
               // in_ready already guaranteed load_ok, so the full word always loads.
               emit_s  = 1'b1;
               idx_d   = '0;
               state_d = IDLE;
            end else if (flush && (n_s != '0)) begin
               if (load_ok_s) begin
                  emit_s  = 1'b1;
                  idx_d   = '0;
                  state_d = IDLE;
               end else begin
                  idx_d   = n_s[IW-1:0];
                  state_d = FLUSH_WAIT;
               end
            end else if (accept_s) begin
               idx_d   = idx_q + IW'(1);
               state_d = FILL;
            end else begin
               state_d = state_q;
            end
         end
         FLUSH_WAIT: begin
            if (load_ok_s) begin
               emit_s  = 1'b1;
               idx_d   = '0;
               state_d = IDLE;
            end else begin
               state_d = FLUSH_WAIT;
            end
         end
         default: begin
            idx_d   = '0;
            state_d = IDLE;
         end
      endcase

      if (emit_s) begin
         out_valid_d = 1'b1;
         count_d     = emit_n_s;
         for (int l = 0; l < W; l++) begin
            foo_d[l] = (l < int'(emit_n_s)) ? stage_m_s[l] : PAD;
         end
      end else begin
         count_d = count_q;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         stage_q     <= '0;
         out_valid_q <= 1'b0;
         count_q     <= '0;
         for (int l = 0; l < W; l++) begin
            foo_q[l] <= 1'b0;
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         stage_q     <= stage_d;
         out_valid_q <= out_valid_d;
         count_q     <= count_d;
         foo_q       <= foo_d;
      end
   end

endmodule

// File: tb/tb_lane_collector.sv
// Directed bench for lane_collector (W=4, PAD=0); inputs change on negedge, outputs
// are sampled 1ns later so registered values reflect the preceding posedge.
module tb_lane_collector;

   localparam int W = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic       in_bit;
   logic       flush;
   logic       out_valid;
   logic       out_ready;
   logic       foo [W-1:0];
   logic [2:0] out_count;

   int n_checks = 0;
   int n_errors = 0;

   lane_collector #(.W(W), .PAD(1'b0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bit    (in_bit),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .foo       (foo),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] foo_pk();
      logic [W-1:0] p;
      for (int i = 0; i < W; i++) p[i] = foo[i];
      return p;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic b, input logic f, input logic r);
      @(negedge clk);
      in_valid  = v;
      in_bit    = b;
      flush     = f;
      out_ready = r;
      #1;
   endtask

   task automatic check_word(input string tag, input logic v, input logic [W-1:0] w,
                             input logic [2:0] c);
      check_val({tag, "_valid"}, 32'(out_valid), 32'(v));
      check_val({tag, "_foo"},   32'(foo_pk()),  32'(w));
      check_val({tag, "_count"}, 32'(out_count), 32'(c));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; flush = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      rst_n = 1'b1; in_valid = 1'b0; in_bit = 1'b0; flush = 1'b0; out_ready = 1'b0;
      do_reset();
      check_word("reset", 1'b0, 4'b0000, 3'd0);
      check_val("reset_in_ready", 32'(in_ready), 32'd1);

      // T1: stream 1,0,1,1 with out_ready=1
      drive(1'b1, 1'b1, 1'b0, 1'b1); check_val("t1_rdy0", 32'(in_ready), 32'd1);
      drive(1'b1, 1'b0, 1'b0, 1'b1); check_val("t1_rdy1", 32'(in_ready), 32'd1);
      drive(1'b1, 1'b1, 1'b0, 1'b1); check_val("t1_rdy2", 32'(in_ready), 32'd1);
      drive(1'b1, 1'b1, 1'b0, 1'b1); check_val("t1_rdy3", 32'(in_ready), 32'd1);
      check_val("t1_no_early_valid", 32'(out_valid), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check_word("t1_word", 1'b1, 4'b1101, 3'd4);

      // T2: word A held, B = 0,1,1,0 stalls on its last bit
      drive(1'b1, 1'b0, 1'b0, 1'b0); check_val("t2_rdy0", 32'(in_ready), 32'd1);
      drive(1'b1, 1'b1, 1'b0, 1'b0); check_val("t2_rdy1", 32'(in_ready), 32'd1);
      drive(1'b1, 1'b1, 1'b0, 1'b0); check_val("t2_rdy2", 32'(in_ready), 32'd1);
      drive(1'b1, 1'b0, 1'b0, 1'b0); check_val("t2_stall0", 32'(in_ready), 32'd0);
      check_word("t2_hold0", 1'b1, 4'b1101, 3'd4);
      drive(1'b1, 1'b0, 1'b0, 1'b0); check_val("t2_stall1", 32'(in_ready), 32'd0);
      check_word("t2_hold1", 1'b1, 4'b1101, 3'd4);
      drive(1'b1, 1'b0, 1'b0, 1'b1); check_val("t2_release", 32'(in_ready), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check_word("t2_wordB", 1'b1, 4'b0110, 3'd4);

      // T3: drain B, then 1,1 + flush -> 1,1,0,0 count 2
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b1); check_val("t3_drained", 32'(out_valid), 32'd0);
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check_word("t3_partial", 1'b1, 4'b0011, 3'd2);

      // T4: output full, stage 1,0, flush -> FLUSH_WAIT until out_ready
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0); check_val("t4_wait_rdy", 32'(in_ready), 32'd0);
      check_word("t4_hold", 1'b1, 4'b0011, 3'd2);
      drive(1'b0, 1'b0, 1'b1, 1'b0); check_val("t4_wait_rdy2", 32'(in_ready), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check_word("t4_partial", 1'b1, 4'b0001, 3'd2);
      check_val("t4_idle_rdy", 32'(in_ready), 32'd1);

      // T5: flush in IDLE does nothing; flush with 4th bit is a full word
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b1); check_val("t5_no_emit", 32'(out_valid), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check_word("t5_full_flush", 1'b1, 4'b1010, 3'd4);

      // T6: reset mid-word with output valid, then a clean word from lane 0
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      do_reset();
      check_word("t6_reset", 1'b0, 4'b0000, 3'd0);
      check_val("t6_rdy", 32'(in_ready), 32'd1);
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check_word("t6_clean", 1'b1, 4'b1001, 3'd4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
